// File: rtl/status_led_pkg.sv
// Shared encodings for the status LED driver: channel modes, pattern states
// and the timing constants used by the per-channel pattern engines.
package status_led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_CODE  = 2'd3;

  // BLINK and CODE share the state register; the first state of both is 0
  localparam logic [1:0] ST_B_ON    = 2'd0;
  localparam logic [1:0] ST_B_OFF   = 2'd1;
  localparam logic [1:0] ST_C_ON    = 2'd0;
  localparam logic [1:0] ST_C_OFF   = 2'd1;
  localparam logic [1:0] ST_C_GAP   = 2'd2;
  localparam logic [1:0] ST_FIRST   = 2'd0;

  localparam int CODE_GAP_MULT = 4;
  localparam int PERIOD_W      = 16;
  localparam int TMR_W         = 18;

  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? PERIOD_W'(1) : p;
  endfunction

endpackage

// File: rtl/status_led_chan.sv
// One LED channel: latched configuration plus the BLINK / CODE pattern engine.
// Advances on the shared tick; a config write restarts the pattern and wins over tick.
module status_led_chan
  import status_led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int COUNT_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  wr,
  input  logic [1:0]            mode,
  input  logic [PWM_BITS-1:0]   duty,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [COUNT_BITS-1:0] count,
  output logic                  lit,
  output logic [PWM_BITS-1:0]   duty_q
);

  logic [1:0]            mode_q;
  logic [PERIOD_W-1:0]   per_q;
  logic [COUNT_BITS-1:0] cnt_q;
  logic [COUNT_BITS-1:0] pcnt_q;
  logic [1:0]            st_q;
  logic [TMR_W-1:0]      tmr_q;

  logic [TMR_W-1:0]      per_m1;
  logic [TMR_W-1:0]      gap_m1;
  logic                  tmr_end;

  // per_q is never 0, so neither terminal value can underflow
  assign per_m1  = TMR_W'(per_q) - TMR_W'(1);
  assign gap_m1  = (TMR_W'(per_q) * TMR_W'(CODE_GAP_MULT)) - TMR_W'(1);
  assign tmr_end = (mode_q == MODE_CODE && st_q == ST_C_GAP) ? (tmr_q == gap_m1)
                                                             : (tmr_q == per_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
      duty_q <= '0;
      per_q  <= PERIOD_W'(1);
      cnt_q  <= '0;
      pcnt_q <= '0;
      st_q   <= ST_FIRST;
      tmr_q  <= '0;
    end else if (wr) begin
      mode_q <= mode;
      duty_q <= duty;
      per_q  <= eff_period(period);
      cnt_q  <= count;
      pcnt_q <= '0;
      st_q   <= ST_FIRST;
      tmr_q  <= '0;
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: begin
          if (tmr_end) begin
            tmr_q <= '0;
            st_q  <= (st_q == ST_B_ON) ? ST_B_OFF : ST_B_ON;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        MODE_CODE: begin
          // count == 0 freezes the engine; lit stays low so it reads as OFF
          if (cnt_q != '0) begin
            if (tmr_end) begin
              tmr_q <= '0;
              case (st_q)
                ST_C_ON: begin
                  st_q   <= ST_C_OFF;
                  pcnt_q <= pcnt_q + COUNT_BITS'(1);
                end
                ST_C_OFF: begin
                  if (pcnt_q < cnt_q) begin
                    st_q <= ST_C_ON;
                  end else begin
                    st_q   <= ST_C_GAP;
                    pcnt_q <= '0;
                  end
                end
                default: st_q <= ST_C_ON;
              endcase
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lit = 1'b0;
    case (mode_q)
      MODE_ON:    lit = 1'b1;
      MODE_BLINK: lit = (st_q == ST_B_ON);
      MODE_CODE:  lit = (st_q == ST_C_ON) && (cnt_q != '0);
      default:    lit = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_led_ctrl.sv
// Multi-channel status LED driver: shared tick prescaler and PWM counter,
// per-channel pattern engines, registered brightness-gated outputs.
module status_led_ctrl
  import status_led_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CLK_HZ     = 100000000,
  parameter int TICK_HZ    = 1000,
  parameter int PWM_BITS   = 8,
  parameter int COUNT_BITS = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                     cfg_mode,
  input  logic [PWM_BITS-1:0]                            cfg_duty,
  input  logic [15:0]                                    cfg_period,
  input  logic [COUNT_BITS-1:0]                          cfg_count,
  output logic [CHANNELS-1:0]                            led,
  output logic                                           tick
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  logic [PS_W-1:0]                    presc_q;
  logic [PWM_BITS-1:0]                pwm_q;
  logic [CHANNELS-1:0]                lit;
  logic [CHANNELS-1:0]                bright;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  duty_q;

  assign tick = (presc_q == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pwm_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PS_W'(1);
      pwm_q   <= pwm_q + PWM_BITS'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    status_led_chan #(
      .PWM_BITS   (PWM_BITS),
      .COUNT_BITS (COUNT_BITS)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .wr     (cfg_we && (cfg_ch == CH_W'(g))),
      .mode   (cfg_mode),
      .duty   (cfg_duty),
      .period (cfg_period),
      .count  (cfg_count),
      .lit    (lit[g]),
      .duty_q (duty_q[g])
    );

    // all-ones duty is forced on so full brightness has no dark PWM slot
    assign bright[g] = (&duty_q[g]) | (pwm_q < duty_q[g]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= '0;
    else        led <= lit & bright;
  end

endmodule

// File: tb/tb_status_led_ctrl.sv
// Bench for status_led_ctrl: cycle-level model computing each channel's lit
// value from ticks elapsed since its last write, checked against two DUT sizes.
module tb_status_led_ctrl;

  localparam int CH       = 4;
  localparam int DIV      = 10;
  localparam int PWM_MAX  = 15;
  localparam int CODE_GAP = 4;

  logic        clk, rst_n, cfg_we;
  logic [1:0]  cfg_ch, cfg_mode;
  logic [3:0]  cfg_duty, cfg_count;
  logic [15:0] cfg_period;
  logic [3:0]  led;
  logic        tick;
  logic [2:0]  led3;
  logic        tick3;

  status_led_ctrl #(.CHANNELS(4), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(4), .COUNT_BITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .cfg_period(cfg_period), .cfg_count(cfg_count), .led(led), .tick(tick));

  // 3-channel copy: cfg_ch=3 is out of range here and must change nothing
  status_led_ctrl #(.CHANNELS(3), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(4), .COUNT_BITS(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .cfg_period(cfg_period), .cfg_count(cfg_count), .led(led3), .tick(tick3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total, bad;
  int m_mode[CH], m_duty[CH], m_per[CH], m_cnt[CH], m_t[CH];
  int m_presc, m_p;
  logic [3:0] exp_led;
  logic       exp_tick;

  function automatic bit m_lit(int i);
    int per, r;
    per = m_per[i];
    case (m_mode[i])
      1: return 1'b1;
      2: return ((m_t[i] / per) % 2) == 0;
      3: begin
        if (m_cnt[i] == 0) return 1'b0;
        r = m_t[i] % (per * (2 * m_cnt[i] + CODE_GAP));
        return (r < 2 * per * m_cnt[i]) && ((r / per) % 2 == 0);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_mode[i] = 0; m_duty[i] = 0; m_per[i] = 1; m_cnt[i] = 0; m_t[i] = 0;
    end
    m_presc = 0; m_p = 0; exp_led = '0; exp_tick = 1'b0;
  endtask

  task automatic step();
    bit tk;
    @(posedge clk);
    for (int i = 0; i < CH; i++)
      exp_led[i] = m_lit(i) && (m_duty[i] == PWM_MAX || m_p < m_duty[i]);
    tk = (m_presc == DIV - 1);
    for (int i = 0; i < CH; i++) begin
      if (cfg_we && int'(cfg_ch) == i) begin
        m_mode[i] = int'(cfg_mode); m_duty[i] = int'(cfg_duty);
        m_per[i]  = (cfg_period == 16'd0) ? 1 : int'(cfg_period);
        m_cnt[i]  = int'(cfg_count); m_t[i] = 0;
      end else if (tk) begin
        m_t[i]++;
      end
    end
    m_presc  = (m_presc + 1) % DIV;
    m_p      = (m_p + 1) % (PWM_MAX + 1);
    exp_tick = (m_presc == DIV - 1);
    #1 cfg_we = 1'b0;
  endtask

  task automatic wr(int ch, int mode, int duty, int per, int cnt);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode);
    cfg_duty = 4'(duty); cfg_period = 16'(per); cfg_count = 4'(cnt);
    step();
  endtask

  task automatic test_reset();
    int first;
    rst_n = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_duty = '0; cfg_period = '0; cfg_count = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (led !== 4'b0 || tick !== 1'b0 || led3 !== 3'b0) begin
      bad++; $display("FAIL reset_state: led=%b tick=%b led3=%b, want all 0", led, tick, led3);
    end
    model_reset();
    rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL reset_release: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
      if (tick === 1'b1 && first == 0) first = k;
    end
    total++;
    if (first != DIV - 1) begin
      bad++; $display("FAIL first_tick: edge %0d, want %0d", first, DIV - 1);
    end
  endtask

  task automatic test_on();
    int hi;
    wr(0, 1, 15, 1, 0);
    repeat (40) begin
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL on_full: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
    end
    wr(0, 1, 4, 1, 0);
    repeat (16) step();
    hi = 0;
    repeat (32) begin
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL on_duty4: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
      hi += int'(led[0]);
    end
    total++;
    if (hi != 8) begin
      bad++; $display("FAIL duty4_ratio: high %0d of 32, want 8", hi);
    end
    wr(0, 1, 0, 1, 0);
    step();
    hi = 0;
    repeat (32) begin
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL on_duty0: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
      hi += int'(led[0]);
    end
    total++;
    if (hi != 0) begin
      bad++; $display("FAIL duty0_dark: high %0d of 32, want 0", hi);
    end
  endtask

  task automatic test_blink();
    int edges;
    logic prev;
    wr(1, 2, 15, 2, 0);
    repeat (60) begin
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL blink_p2: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
    end
    prev = led[1]; edges = 0;
    repeat (80) begin
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL blink_p2: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
      if (led[1] !== prev) edges++;
      prev = led[1];
    end
    total++;
    if (edges != 4) begin
      bad++; $display("FAIL blink_rate: %0d toggles in 80 cycles, want 4", edges);
    end
    wr(1, 2, 15, 0, 0);
    repeat (60) begin
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL blink_p0: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
    end
  endtask

  task automatic test_code();
    int rises;
    logic prev;
    wr(2, 3, 15, 1, 3);
    repeat (100) begin
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL code_3: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
    end
    prev = led[2]; rises = 0;
    repeat (100) begin
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL code_3: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
      if (led[2] === 1'b1 && prev === 1'b0) rises++;
      prev = led[2];
    end
    total++;
    if (rises != 3) begin
      bad++; $display("FAIL code_pulses: %0d pulses per 100 cycles, want 3", rises);
    end
    wr(2, 3, 15, 1, 0);
    repeat (60) begin
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0] || led[2] !== 1'b0) begin
        bad++; $display("FAIL code_0: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
    end
  endtask

  task automatic test_rewrite();
    bit found;
    wr(0, 1, 15, 1, 0);
    wr(1, 2, 15, 2, 0);
    wr(2, 3, 15, 1, 3);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ((m_t[1] / m_per[1]) % 2 == 1 && m_presc == DIV - 1) begin
        found = 1'b1;
        break;
      end
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL rewrite_pre: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rewrite_search: no B_OFF tick within 400 cycles, want one");
    end
    wr(1, 2, 15, 2, 0);
    step(); total++;
    if (led[1] !== 1'b1 || led !== exp_led) begin
      bad++; $display("FAIL rewrite_restart: led=%b, want led=%b with led[1]=1", led, exp_led);
    end
    wr(3, 1, 15, 1, 0);
    repeat (60) begin
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL rewrite_post: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
    end
  endtask

  task automatic test_random();
    repeat (600) begin
      if ($urandom_range(7) == 0)
        wr(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(15)),
           int'($urandom_range(3)), int'($urandom_range(3)));
      else
        step();
      total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL random: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
    end
  endtask

  task automatic test_async_reset();
    wr(0, 1, 15, 1, 0);
    wr(1, 2, 15, 1, 0);
    repeat (5) step();
    total++;
    if (led[0] !== 1'b1) begin
      bad++; $display("FAIL pre_reset: led[0]=%b, want 1", led[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (led !== 4'b0 || led3 !== 3'b0 || tick !== 1'b0) begin
      bad++; $display("FAIL async_reset: led=%b led3=%b tick=%b, want all 0", led, led3, tick);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) begin
      step(); total++;
      if (led !== exp_led || tick !== exp_tick || led3 !== exp_led[2:0]) begin
        bad++; $display("FAIL after_reset: led=%b tick=%b led3=%b, want led=%b tick=%b", led, tick, led3, exp_led, exp_tick);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_on();
    test_blink();
    test_code();
    test_rewrite();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
